dmem_ctrl: RTL and testbench

- Data-memory controller directly downstream of the MEM stage.
- Consumes the MEM stage's memory strobes (chip enable, write enable, word address, store data) and returns load data on the MEM stage's memory-read input.
- Models a wait-state memory: holds the pipeline with a stall request until each access completes.
- Owns the word storage array.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_if.sv | 26 ++
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_ctrl.sv | 127 ++++++++++++
 tb/tb_dmem_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller and its MEM-stage client.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    localparam int DMEM_DEPTH_DEFAULT = 1024;
    localparam int DMEM_WAIT_DEFAULT  = 2;

    localparam logic [4:0] ALU_OP_LW = 5'b10100;
    localparam logic [4:0] ALU_OP_SW = 5'b10101;

    function automatic logic word_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage <-> data-memory strobe bundle. be_i exists only when DMEM_BYTE_EN is defined.
interface dmem_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
`ifdef DMEM_BYTE_EN
    logic [3:0]  be_i;
`endif
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        misalign_o;
    logic        busy_o;

`ifdef DMEM_BYTE_EN
    modport master (output ce_i, we_i, addr_i, wdata_i, be_i,
                    input  rdata_o, stall_o, misalign_o, busy_o);
    modport slave  (input  ce_i, we_i, addr_i, wdata_i, be_i,
                    output rdata_o, stall_o, misalign_o, busy_o);
`else
    modport master (output ce_i, we_i, addr_i, wdata_i,
                    input  rdata_o, stall_o, misalign_o, busy_o);
    modport slave  (input  ce_i, we_i, addr_i, wdata_i,
                    output rdata_o, stall_o, misalign_o, busy_o);
`endif
endinterface

// File: rtl/dmem_array.sv
// Single-port word storage split into four byte lanes; lane writes are individually enabled.
module dmem_array #(
    parameter  int DEPTH_WORDS = 1024,
    localparam int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] rd_q;

            // Storage has no reset so it maps onto block RAM; only the read register clears.
            always_ff @(posedge clk) begin
                if (wr_en && be[gi]) begin
                    lane_mem[idx] <= wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_q <= 8'h00;
                end else if (rd_en) begin
                    rd_q <= lane_mem[idx];
                end
            end

            assign rdata[8*gi +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_ctrl.sv
// Wait-state data-memory controller: serialises MEM-stage accesses and stalls until each completes.
// Optional byte-lane stores are enabled by defining DMEM_BYTE_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = DMEM_WAIT_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_state_e   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;

    logic          stall;
    logic          misalign;
    logic          access;
    logic          access_en;
    logic [3:0]    be_in;
    logic          unused_addr_hi;

`ifdef DMEM_BYTE_EN
    assign be_in = bus.be_i;
`else
    assign be_in = 4'hF;
`endif

    // Upper address bits are deliberately dropped so out-of-range addresses wrap.
    assign unused_addr_hi = ^bus.addr_i[31:AW+2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        stall    = 1'b0;
        misalign = 1'b0;
        access   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ce_i) begin
                    if (word_aligned(bus.addr_i[1:0])) begin
                        stall   = 1'b1;
                        idx_d   = bus.addr_i[AW+1:2];
                        we_d    = bus.we_i;
                        wdata_d = bus.wdata_i;
                        be_d    = be_in;
                        cnt_d   = WAIT_INIT;
                        if (WAIT_CYCLES > 0) begin
                            state_d = ST_WAIT;
                        end else begin
                            state_d = ST_DONE;
                            access  = 1'b1;
                        end
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_DONE;
                    access  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // The access fires on the edge that enters DONE; a reset on that edge cancels it.
    assign access_en = access & rst;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .wr_en (access_en & we_d),
        .rd_en (access_en & ~we_d),
        .idx   (idx_d),
        .wdata (wdata_d),
        .be    (be_d),
        .rdata (bus.rdata_o)
    );

    assign bus.stall_o    = stall;
    assign bus.misalign_o = misalign;
    assign bus.busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: table of accesses on a 2-wait-state instance plus hand sequences
// for reset mid-store and a zero-wait-state instance.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_if bus2 ();
    dmem_if bus0 ();

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut_w2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs[16];
    int          n_vec;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cur_id = -1;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %h, expected %h", nm, cur_id, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] exp_rdata, input logic exp_mis);
        vecs[i].we        = we;
        vecs[i].addr      = addr;
        vecs[i].wdata     = wdata;
        vecs[i].be        = be;
        vecs[i].exp_rdata = exp_rdata;
        vecs[i].exp_mis   = exp_mis;
    endtask

    // One complete request on the 2-wait-state instance, checked cycle by cycle.
    task automatic run_req2(input vec_t v);
        int          stalls;
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        bus2.ce_i    = 1'b1;
        bus2.we_i    = v.we;
        bus2.addr_i  = v.addr;
        bus2.wdata_i = v.wdata;
`ifdef DMEM_BYTE_EN
        bus2.be_i    = v.be;
`endif
        if (!v.we && !v.exp_mis) exp_q.push_back(v.exp_rdata);
        @(negedge clk);
        chk("req_misalign", {31'h0, bus2.misalign_o}, {31'h0, v.exp_mis});
        if (v.exp_mis) begin
            chk("mis_stall", {31'h0, bus2.stall_o}, 32'h0);
            @(posedge clk); #1;
            bus2.ce_i = 1'b0;
            @(negedge clk);
            chk("mis_busy", {31'h0, bus2.busy_o}, 32'h0);
            chk("mis_rdata_hold", bus2.rdata_o, last_rd);
            $display("step %0d: misaligned addr %h rejected", cur_id, v.addr);
            return;
        end
        stalls = 0;
        while (bus2.stall_o && stalls < 40) begin
            stalls++;
            @(posedge clk); #1;
            // Latched copies must be used: scramble the live inputs.
            bus2.ce_i    = 1'($urandom_range(0, 1));
            bus2.we_i    = ~v.we;
            bus2.addr_i  = $urandom & 32'hFFFF_FFFC;
            bus2.wdata_i = $urandom;
            @(negedge clk);
        end
        chk("stall_cycles", stalls, 32'd3);
        chk("done_busy", {31'h0, bus2.busy_o}, 32'h1);
        if (!v.we) begin
            exp_rd = exp_q.pop_front();
            chk("load_rdata", bus2.rdata_o, exp_rd);
            last_rd = exp_rd;
        end else begin
            chk("store_rdata_hold", bus2.rdata_o, last_rd);
        end
        @(posedge clk); #1;
        bus2.ce_i = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'h0, bus2.busy_o}, 32'h0);
        chk("idle_stall", {31'h0, bus2.stall_o}, 32'h0);
        chk("idle_rdata_hold", bus2.rdata_o, last_rd);
        $display("step %0d: %s addr %h data %h stalls %0d rdata %h",
                 cur_id, v.we ? "store" : "load", v.addr, v.wdata, stalls, bus2.rdata_o);
    endtask

    // Zero-wait-state request: one stall cycle, then DONE with scrambled inputs.
    task automatic run_req0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata);
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        bus0.ce_i    = 1'b1;
        bus0.we_i    = we;
        bus0.addr_i  = addr;
        bus0.wdata_i = wdata;
        if (!we) exp_q.push_back(exp_rdata);
        @(negedge clk);
        chk("w0_req_stall", {31'h0, bus0.stall_o}, 32'h1);
        chk("w0_req_busy", {31'h0, bus0.busy_o}, 32'h0);
        @(posedge clk); #1;
        bus0.ce_i    = 1'b1;
        bus0.we_i    = 1'b1;
        bus0.addr_i  = 32'h8;
        bus0.wdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("w0_done_stall", {31'h0, bus0.stall_o}, 32'h0);
        chk("w0_done_busy", {31'h0, bus0.busy_o}, 32'h1);
        if (!we) begin
            exp_rd = exp_q.pop_front();
            chk("w0_load_rdata", bus0.rdata_o, exp_rd);
        end
        $display("w0 step %0d: %s addr %h rdata %h", cur_id, we ? "store" : "load", addr, bus0.rdata_o);
    endtask

    initial begin
        rst = 1'b0;
        bus2.ce_i = 1'b0; bus2.we_i = 1'b0; bus2.addr_i = 32'h0; bus2.wdata_i = 32'h0;
        bus0.ce_i = 1'b0; bus0.we_i = 1'b0; bus0.addr_i = 32'h0; bus0.wdata_i = 32'h0;
`ifdef DMEM_BYTE_EN
        bus2.be_i = 4'hF;
        bus0.be_i = 4'hF;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'h0, bus2.stall_o}, 32'h0);
        chk("rst_busy", {31'h0, bus2.busy_o}, 32'h0);
        chk("rst_misalign", {31'h0, bus2.misalign_o}, 32'h0);
        chk("rst_rdata", bus2.rdata_o, 32'h0);
        $display("reset: stall %b busy %b rdata %h", bus2.stall_o, bus2.busy_o, bus2.rdata_o);
        @(posedge clk); #1;
        rst = 1'b1;

        // Known prior contents at 0x10, then a store there that reset aborts.
        cur_id = 100;
        set_vec(0, 1'b1, 32'h10, 32'h1357_9BDF, 4'hF, 32'h0, 1'b0);
        run_req2(vecs[0]);
        cur_id = 101;
        @(posedge clk); #1;
        bus2.ce_i = 1'b1; bus2.we_i = 1'b1; bus2.addr_i = 32'h10; bus2.wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mid_req_stall", {31'h0, bus2.stall_o}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus2.ce_i = 1'b0;
        @(negedge clk);
        chk("mid_wait_busy", {31'h0, bus2.busy_o}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_stall", {31'h0, bus2.stall_o}, 32'h0);
        chk("mid_rst_busy", {31'h0, bus2.busy_o}, 32'h0);
        chk("mid_rst_rdata", bus2.rdata_o, 32'h0);
        $display("reset mid-store: stall %b busy %b rdata %h", bus2.stall_o, bus2.busy_o, bus2.rdata_o);
        last_rd = 32'h0;

        set_vec(0,  1'b0, 32'h0000_0010, 32'h0,          4'hF, 32'h1357_9BDF, 1'b0);
        set_vec(1,  1'b1, 32'h0000_0040, 32'h1234_5678,  4'hF, 32'h0,         1'b0);
        set_vec(2,  1'b0, 32'h0000_0040, 32'h0,          4'hF, 32'h1234_5678, 1'b0);
        set_vec(3,  1'b0, 32'h0000_0042, 32'h0,          4'hF, 32'h0,         1'b1);
        set_vec(4,  1'b1, 32'h0000_1000, 32'hA5A5_A5A5,  4'hF, 32'h0,         1'b0);
        set_vec(5,  1'b0, 32'h0000_0000, 32'h0,          4'hF, 32'hA5A5_A5A5, 1'b0);
        set_vec(6,  1'b1, 32'h0000_0FFC, 32'hCAFE_F00D,  4'hF, 32'h0,         1'b0);
        set_vec(7,  1'b0, 32'hFFFF_FFFC, 32'h0,          4'hF, 32'hCAFE_F00D, 1'b0);
        set_vec(8,  1'b1, 32'h0000_0041, 32'h0BAD_0BAD,  4'hF, 32'h0,         1'b1);
        set_vec(9,  1'b0, 32'h0000_0040, 32'h0,          4'hF, 32'h1234_5678, 1'b0);
        set_vec(10, 1'b1, 32'h0000_0020, 32'h1122_3344,  4'hF, 32'h0,         1'b0);
        set_vec(11, 1'b0, 32'h0000_0020, 32'h0,          4'hF, 32'h1122_3344, 1'b0);
        n_vec = 12;
`ifdef DMEM_BYTE_EN
        set_vec(12, 1'b1, 32'h0000_0020, 32'hAABB_CCDD,  4'b0101, 32'h0,         1'b0);
        set_vec(13, 1'b0, 32'h0000_0020, 32'h0,          4'b0000, 32'h11BB_33DD, 1'b0);
        set_vec(14, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF,  4'b0000, 32'h0,         1'b0);
        set_vec(15, 1'b0, 32'h0000_0020, 32'h0,          4'hF,    32'h11BB_33DD, 1'b0);
        n_vec = 16;
`endif
        for (int i = 0; i < n_vec; i++) begin
            cur_id = i;
            run_req2(vecs[i]);
        end

        // Zero-wait instance: back-to-back requests, DONE-cycle inputs must not land.
        cur_id = 200; run_req0(1'b1, 32'h8, 32'h8888_8888, 32'h0);
        cur_id = 201; run_req0(1'b1, 32'h0, 32'h0A0A_0A0A, 32'h0);
        cur_id = 202; run_req0(1'b1, 32'h4, 32'h0B0B_0B0B, 32'h0);
        cur_id = 203; run_req0(1'b0, 32'h0, 32'h0,        32'h0A0A_0A0A);
        cur_id = 204; run_req0(1'b0, 32'h4, 32'h0,        32'h0B0B_0B0B);
        cur_id = 205; run_req0(1'b0, 32'h8, 32'h0,        32'h8888_8888);
        @(posedge clk); #1;
        bus0.ce_i = 1'b0;
        @(negedge clk);
        chk("w0_idle_busy", {31'h0, bus0.busy_o}, 32'h0);
        chk("w0_idle_rdata_hold", bus0.rdata_o, 32'h8888_8888);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
